mem_arb_ctrl: RTL and testbench
===============================

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  SZ_W  2'b00  access size code: 32-bit word, 4 bytes
  SZ_H  2'b01  access size code: 16-bit halfword, 2 bytes
  SZ_B  2'b10  access size code: 8-bit byte, 1 byte
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset are fixed as one clock with an asynchronous, active-low reset.
  clk       in   1   single clock; all state changes on its rising edge
  rst_n     in   1   asynchronous, active-low reset
  if_req    in   1   instruction-fetch request; always a 32-bit read
  if_addr   in   32  instruction-fetch byte address
  if_ack    out  1   one-cycle pulse; if_rdata is valid in this cycle
  if_rdata  out  32  fetched word
  d_req     in   1   data-port request
  d_we      in   1   1 = write, 0 = read
  d_size    in   2   access size: SZ_W, SZ_H or SZ_B
  d_sign    in   1   1 = sign-extend read data, 0 = zero-extend
  d_addr    in   32  data byte address
  d_wdata   in   32  write data, right-justified
  d_ack     out  1   one-cycle completion pulse
  d_err     out  1   pulses together with d_ack when d_size is 2'b11
  d_rdata   out  32  extended read data
  mem_a     out  32  byte address to the memory
  mem_we    out  1   byte write strobe
  mem_re    out  1   byte read strobe
  mem_wd    out  8   write byte
  mem_rd    in   8   read byte; combinational in the same cycle as mem_re

Function
REQ-003 The controller SHALL have three states: IDLE, XFER and DONE; a 2-bit byte counter k; and a 2-bit remaining count n.
REQ-004 In IDLE with at least one request high, the controller SHALL grant at the next edge: if only one request is high, grant it; if both are high, grant the port not granted last (last-grant register resets to IF, so data wins the first tie).
REQ-005 On grant, the controller SHALL latch address, write-enable, size, sign and wdata; requester input changes after grant SHALL be ignored; IF grants latch we=0 and size SZ_W.
REQ-006 n SHALL be 4, 2 or 1 for SZ_W, SZ_H or SZ_B.
REQ-007 A data grant with size 2'b11 SHALL go directly to DONE with no memory strobe, d_rdata=0 and d_err=1.
REQ-008 In XFER cycle k (k=0..n-1), the controller SHALL drive mem_a = latched address + k, with 32-bit wrap-around and no alignment check.
REQ-009 In each XFER cycle exactly one of mem_re or mem_we SHALL be high; after the cycle with k=n-1, go to DONE.
REQ-010 Writes SHALL be big-endian: byte k = wdata[8(n-1-k)+7 : 8(n-1-k)], so the most significant byte goes to the lowest address.
REQ-011 Reads SHALL shift mem_rd into an assembly register each XFER cycle, first byte most significant.
REQ-012 In DONE, the granted port's ack SHALL be high for exactly one cycle with its rdata valid; the next state is IDLE.
REQ-013 For SZ_H and SZ_B reads, the result SHALL be sign-extended from bit 15 or bit 7 when d_sign=1, otherwise zero-extended; write acks SHALL return d_rdata=0.
REQ-014 A requester SHALL deassert req at the edge at which it samples ack; req high in IDLE is always a new request.
REQ-015 mem_* outputs SHALL be decoded from registered state only, with no combinational path from requester inputs; outside XFER, mem_re=mem_we=0, mem_a=0 and mem_wd=0.
REQ-016 Latency from the grant edge to ack SHALL be n+1 cycles; for an error access it SHALL be 1 cycle.
REQ-017 rdata outputs SHALL hold their last value until the next ack on the same port.

Reset
REQ-018 While rst_n=0, the controller SHALL be forced immediately to IDLE with k=n=0, last-grant=IF, and all outputs 0; no reset-time memory strobe is issued.
REQ-019 Reset asserted mid-XFER SHALL abort the access without ack; bytes already written remain written.

Verification
REQ-020 Data write: SZ_W, addr 0x10, wdata 0xA1B2C3D4 -> bytes A1, B2, C3, D4 at 0x10..0x13 on 4 consecutive cycles, d_ack 5 cycles after grant.
REQ-021 Signed and unsigned reads: SZ_H read at 0x10 with d_sign=1 -> 0xFFFFA1B2; SZ_B read at 0x13 with d_sign=0 -> 0x000000D4.
REQ-022 Arbitration: if_req and d_req high simultaneously and held -> data is served first, then IF; tie grants alternate D, IF, D, IF.
REQ-023 Illegal size: d_size=2'b11 -> d_ack and d_err high in the same cycle, one cycle after grant, mem_re=mem_we=0 throughout.
REQ-024 Wrap and reset: SZ_W write at 0xFFFFFFFE -> mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; rst_n low during k=1 -> strobes drop at once and no ack is issued.

Source files
------------

// File: rtl/mem_arb_ctrl.sv
// Two-port (fetch/data) arbiter that serialises word, halfword and byte
// accesses onto a byte-wide memory, big-endian, one byte per cycle.
module mem_arb_ctrl #(
    parameter logic [1:0] SZ_W = 2'b00,
    parameter logic [1:0] SZ_H = 2'b01,
    parameter logic [1:0] SZ_B = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_sign,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  mem_wd,
    input  logic [7:0]  mem_rd
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q;
    // holds bytes remaining minus one, which is also the wdata byte index
    logic [1:0]  n_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        sign_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic        gnt_d_q;
    logic        last_d_q;
    logic [23:0] asm_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic        any_req;
    logic        pick_d;
    logic        d_bad;
    logic [31:0] full;
    logic [31:0] rd_ext;

    function automatic logic [1:0] size_rem(input logic [1:0] sz);
        logic [1:0] r;
        r = 2'd0;
        if (sz == SZ_W) r = 2'd3;
        else if (sz == SZ_H) r = 2'd1;
        return r;
    endfunction

    assign any_req = if_req | d_req;
    assign pick_d  = d_req & (~if_req | ~last_d_q);
    assign d_bad   = (d_size == 2'b11);
    assign full    = {asm_q, mem_rd};

    always_comb begin
        rd_ext = full;
        if (size_q == SZ_H)
            rd_ext = {{16{sign_q & full[15]}}, full[15:0]};
        else if (size_q == SZ_B)
            rd_ext = {{24{sign_q & full[7]}}, full[7:0]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req)
                    state_d = (pick_d && d_bad) ? DONE : XFER;
            end
            XFER: begin
                if (n_q == 2'd0)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= 2'd0;
            n_q        <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= SZ_W;
            gnt_d_q    <= 1'b0;
            last_d_q   <= 1'b0;
            asm_q      <= 24'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                gnt_d_q  <= pick_d;
                last_d_q <= pick_d;
                k_q      <= 2'd0;
                asm_q    <= 24'd0;
                if (pick_d) begin
                    addr_q  <= d_addr;
                    we_q    <= d_we;
                    size_q  <= d_size;
                    sign_q  <= d_sign;
                    wdata_q <= d_wdata;
                    err_q   <= d_bad;
                    n_q     <= size_rem(d_size);
                    if (d_bad)
                        d_rdata_q <= 32'd0;
                end else begin
                    addr_q  <= if_addr;
                    we_q    <= 1'b0;
                    size_q  <= SZ_W;
                    sign_q  <= 1'b0;
                    wdata_q <= 32'd0;
                    err_q   <= 1'b0;
                    n_q     <= 2'd3;
                end
            end else if (state_q == XFER) begin
                k_q   <= k_q + 2'd1;
                n_q   <= n_q - 2'd1;
                asm_q <= full[23:0];
                if (n_q == 2'd0) begin
                    if (gnt_d_q)
                        d_rdata_q <= we_q ? 32'd0 : rd_ext;
                    else
                        if_rdata_q <= full;
                end
            end else if (state_q == DONE) begin
                k_q <= 2'd0;
                n_q <= 2'd0;
            end
        end
    end

    assign if_ack   = (state_q == DONE) & ~gnt_d_q;
    assign d_ack    = (state_q == DONE) & gnt_d_q;
    assign d_err    = d_ack & err_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    assign mem_re = (state_q == XFER) & ~we_q;
    assign mem_we = (state_q == XFER) & we_q;
    assign mem_a  = (state_q == XFER) ? addr_q + {30'd0, k_q} : 32'd0;
    assign mem_wd = (state_q == XFER) ? wdata_q[{n_q, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl with a 256-byte memory model
// and hand-computed expected values.
module tb_mem_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_sign;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_a;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_wd;
    logic [7:0]  mem_rd;

    logic [7:0]  mem [256];
    logic [39:0] wlog [$];

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int nstb;
    int errs;

    mem_arb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size),
        .d_sign(d_sign), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:0]];

    always @(posedge clk)
        if (mem_we) mem[mem_a[7:0]] <= mem_wd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one access on either port; returns latency, strobe count, err pulses
    task automatic access(input bit is_if, input bit we,
                          input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd);
        bit done;
        done = 0;
        lat  = 0;
        nstb = 0;
        errs = 0;
        wlog.delete();
        @(negedge clk);
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = a;
        end else begin
            d_req   = 1'b1;
            d_we    = we;
            d_size  = sz;
            d_sign  = sg;
            d_addr  = a;
            d_wdata = wd;
        end
        @(posedge clk);
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (mem_we) wlog.push_back({mem_a, mem_wd});
            if (mem_re || mem_we) nstb++;
            if (d_err) errs++;
            if (if_ack || d_ack) begin
                lat    = c;
                done   = 1;
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("ack_timeout", {31'd0, done}, 32'd1);
    endtask

    logic [31:0] wexp;
    logic [3:0]  ord;
    int          nack;
    bit          saw;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_sign = 1'b0;
        d_addr = '0; d_wdata = '0;
        #1;
        chk("rst_acks", {29'd0, if_ack, d_ack, d_err}, 32'd0);
        chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_rdata", d_rdata | if_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // word write, big-endian
        wexp = 32'hA1B2C3D4;
        access(0, 1, 2'b00, 0, 32'h10, wexp);
        chk("wr_lat", lat, 5);
        chk("wr_nbytes", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("wr_addr", wlog[i][39:8], 32'h10 + i);
            chk("wr_byte", {24'd0, wlog[i][7:0]}, {24'd0, wexp[8*(3-i) +: 8]});
        end
        chk("wr_rdata", d_rdata, 32'd0);
        chk("wr_err", errs, 0);

        access(0, 0, 2'b01, 1, 32'h10, 0);
        chk("rdh_s", d_rdata, 32'hFFFFA1B2);
        chk("rdh_lat", lat, 3);
        access(0, 0, 2'b10, 0, 32'h13, 0);
        chk("rdb_u", d_rdata, 32'h000000D4);
        chk("rdb_lat", lat, 2);
        access(0, 0, 2'b00, 0, 32'h10, 0);
        chk("rdw", d_rdata, 32'hA1B2C3D4);
        access(0, 0, 2'b10, 1, 32'h10, 0);
        chk("rdb_s", d_rdata, 32'hFFFFFFA1);
        access(0, 0, 2'b01, 0, 32'h12, 0);
        chk("rdh_u", d_rdata, 32'h0000C3D4);

        // illegal size
        access(0, 1, 2'b11, 0, 32'h20, 32'hDEADBEEF);
        chk("err_lat", lat, 1);
        chk("err_pulse", errs, 1);
        chk("err_strobes", nstb, 0);
        chk("err_rdata", d_rdata, 32'd0);

        access(1, 0, 2'b00, 0, 32'h10, 0);
        chk("if_rdata", if_rdata, 32'hA1B2C3D4);
        chk("if_lat", lat, 5);
        chk("if_d_hold", d_rdata, 32'd0);

        // tie: both held high
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_sign = 1'b0;
        d_addr = 32'h11;
        ord = '0;
        nack = 0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            @(negedge clk);
            if (d_ack || if_ack) begin
                ord = {ord[2:0], d_ack};
                nack++;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("arb_nack", nack, 4);
        chk("arb_order", {28'd0, ord}, 32'hA);
        chk("arb_drd", d_rdata, 32'h000000B2);

        // wrap-around write
        access(0, 1, 2'b00, 0, 32'hFFFFFFFE, 32'h11223344);
        chk("wrap_n", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("wrap_addr", wlog[i][39:8], 32'hFFFFFFFE + i);

        // reset during k=1
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b00;
        d_addr = 32'hFFFFFFFE; d_wdata = 32'h55667788;
        @(posedge clk);
        @(negedge clk);
        chk("rst_k0_a", mem_a, 32'hFFFFFFFE);
        d_req = 1'b0;
        @(negedge clk);
        chk("rst_k1_a", mem_a, 32'hFFFFFFFF);
        chk("rst_k1_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_we", {31'd0, mem_we}, 32'd0);
        chk("rst_drop_a", mem_a, 32'd0);
        saw = 0;
        repeat (2) begin
            @(negedge clk);
            saw |= d_ack | if_ack;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            saw |= d_ack | if_ack | mem_we;
        end
        chk("rst_no_ack", {31'd0, saw}, 32'd0);
        chk("rst_byte_fe", {24'd0, mem[8'hFE]}, 32'h55);
        chk("rst_byte_ff", {24'd0, mem[8'hFF]}, 32'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
